// File: rtl/fetch_cycle.sv
// fetch_cycle: instruction fetch stage feeding decode.
//   Holds the PC and drives a req/ack instruction-memory port. Each fetched word
//   and its PC are registered into ir/pcout. A one-entry skid buffer absorbs a
//   word that returns while decode is stalled. A redirect that lands while an
//   access is outstanding keeps the old address on the bus until the ack, and
//   that word is then dropped.
//
// Optional build macro: FETCH_PERF_EN adds fetch_count / bubble_count outputs.
//
// Ports:
//   clk          in   1   clock, all state on posedge
//   rst          in   1   asynchronous active-low reset
//   stall        in   1   decode cannot accept; hold ir/pcout/ir_valid
//   redirect     in   1   branch/jump taken; refetch from redirect_pc
//   redirect_pc  in   16  redirect target
//   imem_req     out  1   fetch request
//   imem_addr    out  16  fetch address (stable while request outstanding)
//   imem_ack     in   1   imem_rdata valid for imem_addr this cycle
//   imem_rdata   in   16  instruction word
//   ir           out  16  registered instruction to decode
//   pcout        out  16  PC of ir
//   ir_valid     out  1   ir holds a real instruction (0 = bubble)
//   fetch_count  out  16  (FETCH_PERF_EN) acks whose data was kept
//   bubble_count out  16  (FETCH_PERF_EN) cycles in which ir_valid was written 0
//
// state | meaning
// BOOT  | first cycle after reset release, no request
// FETCH | request at pc, accept word on ack
// SKID  | word parked in skid buffer while decode stalls, no request
// DRAIN | redirect hit an outstanding access; wait for its ack and drop it

module fetch_cycle #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ir,
  output logic [15:0] pcout,
  output logic        ir_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] bubble_count
`endif
);

  typedef enum logic [1:0] {BOOT, FETCH, SKID, DRAIN} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] skid_data;
  logic [15:0] skid_pc;
  logic        skid_valid;
  logic [15:0] pc_next;

  assign pc_next = pc + PC_INC;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      ir         <= NOP_INST;
      pcout      <= 16'h0000;
      ir_valid   <= 1'b0;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      skid_data  <= NOP_INST;
      skid_pc    <= 16'h0000;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          if (redirect) begin
            pc        <= redirect_pc;
            imem_addr <= redirect_pc;
          end else begin
            imem_addr <= pc;
          end
        end

        FETCH: begin
          if (redirect) begin
            ir         <= NOP_INST;
            ir_valid   <= 1'b0;
            skid_valid <= 1'b0;
            pc         <= redirect_pc;
            if (imem_ack) begin
              // returned word belongs to the wrong path; refetch at once
              imem_addr <= redirect_pc;
            end else begin
              // access still outstanding: keep its address until it acks
              state <= DRAIN;
            end
          end else if (imem_ack) begin
            pc        <= pc_next;
            imem_addr <= pc_next;
            if (!stall) begin
              ir       <= imem_rdata;
              pcout    <= pc;
              ir_valid <= 1'b1;
            end else begin
              skid_data  <= imem_rdata;
              skid_pc    <= pc;
              skid_valid <= 1'b1;
              imem_req   <= 1'b0;
              state      <= SKID;
            end
          end else if (!stall) begin
            ir       <= NOP_INST;
            ir_valid <= 1'b0;
          end
        end

        SKID: begin
          if (redirect) begin
            ir         <= NOP_INST;
            ir_valid   <= 1'b0;
            skid_valid <= 1'b0;
            pc         <= redirect_pc;
            imem_addr  <= redirect_pc;
            imem_req   <= 1'b1;
            state      <= FETCH;
          end else if (!stall) begin
            ir         <= skid_data;
            pcout      <= skid_pc;
            ir_valid   <= 1'b1;
            skid_valid <= 1'b0;
            imem_addr  <= pc;
            imem_req   <= 1'b1;
            state      <= FETCH;
          end
        end

        DRAIN: begin
          if (redirect || !stall) begin
            ir       <= NOP_INST;
            ir_valid <= 1'b0;
          end
          if (redirect) begin
            pc <= redirect_pc;
          end
          // the stale access completing ends the drain even if a newer
          // redirect arrives in the same cycle; pc already holds the target
          if (imem_ack) begin
            state     <= FETCH;
            imem_addr <= redirect ? redirect_pc : pc;
          end
        end

        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic fetch_strobe;
  logic bubble_strobe;

  always_comb begin
    fetch_strobe  = 1'b0;
    bubble_strobe = 1'b0;
    case (state)
      FETCH: begin
        fetch_strobe  = imem_ack && !redirect;
        bubble_strobe = redirect || (!imem_ack && !stall);
      end
      SKID:    bubble_strobe = redirect;
      DRAIN:   bubble_strobe = redirect || !stall;
      default: bubble_strobe = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count  <= 16'h0000;
      bubble_count <= 16'h0000;
    end else begin
      if (fetch_strobe) fetch_count <= fetch_count + 16'd1;
      if (bubble_strobe) bubble_count <= bubble_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_cycle.sv
// tb_fetch_cycle: directed scenarios plus randomized stall/redirect/ack traffic,
// checked every cycle against a behavioural model of the fetch stage built from
// flags (booting, skid occupied, stale access outstanding) rather than states.
module tb_fetch_cycle;
  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] ir;
  logic [15:0] pcout;
  logic        ir_valid;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] bubble_count;
`endif

  fetch_cycle dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir), .pcout(pcout),
    .ir_valid(ir_valid)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state
  bit          m_boot;
  logic [15:0] m_pc, m_ir, m_pcout;
  bit          m_valid;
  bit          sk_v;
  logic [15:0] sk_d, sk_p;
  bit          m_stale;
  logic [15:0] m_stale_addr;
  logic [15:0] m_fcnt, m_bcnt;
  bit          xor_mode;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_pc = 16'h0000; m_ir = NOP; m_pcout = 16'h0000; m_valid = 0;
    sk_v = 0; sk_d = 16'h0000; sk_p = 16'h0000; m_stale = 0; m_stale_addr = 16'h0000;
    m_fcnt = 16'h0000; m_bcnt = 16'h0000;
  endtask

  task automatic bubble();
    m_ir = NOP; m_valid = 0; m_bcnt = m_bcnt + 16'd1;
  endtask

  task automatic model_step(input bit st, input bit rd, input logic [15:0] rpc,
                            input bit ack, input logic [15:0] data);
    bit req;
    req = !m_boot && !sk_v;
    if (m_boot) begin
      if (rd) m_pc = rpc;
      m_boot = 0;
      return;
    end
    if (rd) begin
      bubble();
      sk_v = 0;
      if (req && !ack && !m_stale) begin
        m_stale = 1; m_stale_addr = m_pc;
      end else if (req && ack) begin
        m_stale = 0;
      end
      m_pc = rpc;
      return;
    end
    if (sk_v) begin
      if (!st) begin
        m_ir = sk_d; m_pcout = sk_p; m_valid = 1; sk_v = 0;
      end
      return;
    end
    if (m_stale) begin
      if (ack) m_stale = 0;
      if (!st) bubble();
      return;
    end
    if (ack) begin
      if (!st) begin
        m_ir = data; m_pcout = m_pc; m_valid = 1;
      end else begin
        sk_v = 1; sk_d = data; sk_p = m_pc;
      end
      m_pc = m_pc + 16'd2;
      m_fcnt = m_fcnt + 16'd1;
    end else if (!st) begin
      bubble();
    end
  endtask

  task automatic compare_all();
    bit req;
    req = !m_boot && !sk_v;
    chk("req", {15'b0, imem_req}, {15'b0, req});
    if (req) chk("addr", imem_addr, m_stale ? m_stale_addr : m_pc);
    chk("ir", ir, m_ir);
    chk("pcout", pcout, m_pcout);
    chk("ir_valid", {15'b0, ir_valid}, {15'b0, m_valid});
`ifdef FETCH_PERF_EN
    chk("fetch_count", fetch_count, m_fcnt);
    chk("bubble_count", bubble_count, m_bcnt);
`endif
  endtask

  task automatic cyc(input bit st, input bit rd, input logic [15:0] rpc, input bit ack);
    stall = st; redirect = rd; redirect_pc = rpc; imem_ack = ack;
    imem_rdata = xor_mode ? ((m_stale ? m_stale_addr : m_pc) ^ 16'hA5A5) : 16'($urandom);
    @(posedge clk);
    model_step(st, rd, rpc, ack, imem_rdata);
    @(negedge clk);
    compare_all();
  endtask

  // asserts reset part-way through a cycle and checks its immediate effect
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_req", {15'b0, imem_req}, 16'h0000);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_ir", ir, NOP);
    chk("rst_pcout", pcout, 16'h0000);
    chk("rst_valid", {15'b0, ir_valid}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    xor_mode = 1;
    model_reset();
    do_reset();

    // T1: streaming, ack tied high
    cyc(0, 0, 0, 1);
    chk("t1_boot_valid", {15'b0, ir_valid}, 16'h0000);
    cyc(0, 0, 0, 1);
    chk("t1_ir0", ir, 16'hA5A5);
    chk("t1_pc0", pcout, 16'h0000);
    chk("t1_v0", {15'b0, ir_valid}, 16'h0001);
    cyc(0, 0, 0, 1);
    chk("t1_ir1", ir, 16'hA5A7);
    chk("t1_pc1", pcout, 16'h0002);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    chk("t1_pc4", pcout, 16'h0008);

    // T2: stall catches the pc=4 word in the skid buffer
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("t2_hold_ir", ir, 16'hA5A7);
    chk("t2_hold_pc", pcout, 16'h0002);
    chk("t2_skid_req", {15'b0, imem_req}, 16'h0000);
    cyc(0, 0, 0, 1);
    chk("t2_rel_ir", ir, 16'hA5A1);
    chk("t2_rel_pc", pcout, 16'h0004);
    cyc(0, 0, 0, 1);
    chk("t2_next_ir", ir, 16'hA5A3);
    chk("t2_next_pc", pcout, 16'h0006);

    // T3: redirect while waiting for a slow ack
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 1, 16'h0100, 0);
    chk("t3_drain_addr", imem_addr, 16'h0000);
    chk("t3_drain_req", {15'b0, imem_req}, 16'h0001);
    cyc(0, 0, 0, 0);
    chk("t3_drain_addr2", imem_addr, 16'h0000);
    cyc(0, 0, 0, 1);
    chk("t3_dropped", {15'b0, ir_valid}, 16'h0000);
    chk("t3_new_addr", imem_addr, 16'h0100);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("t3_new_pc", pcout, 16'h0100);

    // T4: redirect + stall with a full skid buffer
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 1, 16'h0040, 0);
    chk("t4_ir", ir, NOP);
    chk("t4_valid", {15'b0, ir_valid}, 16'h0000);
    chk("t4_addr", imem_addr, 16'h0040);
    cyc(0, 0, 0, 1);
    chk("t4_pc", pcout, 16'h0040);
    chk("t4_ir2", ir, 16'hA5E5);

    // T5: pc wrap, then reset in the middle of a wait
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 1, 16'hFFFE, 1);
    chk("t5_addr", imem_addr, 16'hFFFE);
    cyc(0, 0, 0, 1);
    chk("t5_pc_fffe", pcout, 16'hFFFE);
    chk("t5_ir_fffe", ir, 16'h5A5B);
    cyc(0, 0, 0, 1);
    chk("t5_pc_wrap", pcout, 16'h0000);
    chk("t5_ir_wrap", ir, 16'hA5A5);
    cyc(0, 0, 0, 0);
    chk("t5_wait_addr", imem_addr, 16'h0002);
    do_reset();

`ifdef FETCH_PERF_EN
    // T6: 5 kept acks, 2 bubbles, 1 discarded ack with redirect
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 16'h0020, 1);
    chk("t6_fetch", fetch_count, 16'd5);
    chk("t6_bubble", bubble_count, 16'd3);
    do_reset();
`endif

    // randomized traffic
    xor_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset();
      cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
          16'($urandom) & 16'hFFFE, $urandom_range(0, 99) < 60);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
